// File: rtl/fir_filter_mac_param_pkg.sv
// Shared definitions for the time-multiplexed FIR filter.
//   fir_state_t : FSM encoding (IDLE / MAC / OUT)
//   acc_width   : accumulator width for given sample/coef widths and tap count
//   coef_one    : largest positive Q1.(COEF_W-1) coefficient, the reset value of h[0]
//   round_sat   : round-half-up, arithmetic shift, then clamp to a signed output range
package fir_filter_mac_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } fir_state_t;

    // Working width for the rounding/saturation helper; wide enough for any
    // sensible DATA_W + COEF_W + log2(TAPS) combination.
    localparam int CALC_W = 64;

    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    function automatic logic [CALC_W-1:0] coef_one(input int coef_w);
        return (64'd1 << (coef_w - 1)) - 64'd1;
    endfunction

    // Adds half an LSB of the output scale before the arithmetic shift so the
    // result rounds to nearest (ties towards +inf), then clamps instead of wrapping.
    function automatic logic signed [CALC_W-1:0] round_sat(
        input logic signed [CALC_W-1:0] acc,
        input int                       shift,
        input int                       out_w
    );
        logic signed [CALC_W-1:0] r;
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        r  = acc;
        if (shift > 0) begin
            r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
        end
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_filter_mac_param_mac.sv
// Registered signed multiply-accumulate used once per tap.
//   clk, reset : clock, asynchronous active-low reset
//   clr        : load accumulator with zero (wins over en)
//   en         : accumulate x*h this cycle
//   x, h       : signed sample and coefficient
//   acc        : signed running sum
module fir_filter_mac_param_mac #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 35
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [COEF_W-1:0] h,
    output logic signed [ACC_W-1:0]  acc
);

    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] prod;

    assign prod = x * h;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/fir_filter_mac_param.sv
// Parametrised FIR filter with one shared multiplier stepped over TAPS cycles.
//   clk, reset           : clock, asynchronous active-low reset
//   in_valid / in_ready  : sample input handshake, data_in signed DATA_W
//   out_valid / out_ready: result handshake, data_out signed OUT_W
//   coef_we/addr/data    : runtime coefficient write (accepted only in IDLE)
//   coef_err             : one-cycle pulse when a coefficient write is dropped
//   state_dbg            : current FSM state
//
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
// in_ready is 1 only in IDLE (and never during reset). out_valid, once raised, stays
// high with data_out stable until the edge on which out_ready is 1.
//
// Timing: accept at edge 0, MAC at edges 1..TAPS, result registered and out_valid
// raised at edge TAPS+1.
module fir_filter_mac_param
    import fir_filter_mac_param_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 8,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [DATA_W-1:0]   data_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [OUT_W-1:0]    data_out,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data,
    output logic                       coef_err,
    output fir_state_t                 state_dbg
);

    localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
    localparam int K_W   = $clog2(TAPS);
    localparam logic [K_W-1:0] K_LAST = K_W'(TAPS - 1);

    fir_state_t state;
    fir_state_t state_next;

    logic accept;
    logic mac_en;
    logic load_out;
    logic out_done;
    logic coef_ok;

    logic [K_W-1:0]            k;
    logic signed [DATA_W-1:0]  x_line [TAPS];
    logic signed [COEF_W-1:0]  h_ram  [TAPS];
    logic signed [ACC_W-1:0]   acc;
    logic signed [CALC_W-1:0]  result;

    assign in_ready  = reset && (state == ST_IDLE);
    assign state_dbg = state;
    assign coef_ok   = (state == ST_IDLE) && (32'(coef_addr) < TAPS);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // OUT has two phases distinguished by out_valid: first cycle registers the
    // rounded result, then it waits for the downstream handshake.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        mac_en     = 1'b0;
        load_out   = 1'b0;
        out_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = ST_MAC;
                end
            end
            ST_MAC: begin
                mac_en = 1'b1;
                if (k == K_LAST) begin
                    state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                if (!out_valid) begin
                    load_out = 1'b1;
                end else if (out_ready) begin
                    out_done   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------- tap counter ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k <= '0;
        end else if (accept) begin
            k <= '0;
        end else if (mac_en) begin
            k <= k + K_W'(1);
        end
    end

    // ---------------- delay line ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) begin
                x_line[i] <= '0;
            end
        end else if (accept) begin
            x_line[0] <= data_in;
            for (int i = 1; i < TAPS; i++) begin
                x_line[i] <= x_line[i-1];
            end
        end
    end

    // ---------------- coefficient registers ----------------
    // A write coincident with acceptance lands at edge 0, before the first MAC
    // cycle reads h[0], so it applies to that sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) begin
                if (i == 0) begin
                    h_ram[i] <= COEF_W'(coef_one(COEF_W));
                end else begin
                    h_ram[i] <= '0;
                end
            end
            coef_err <= 1'b0;
        end else begin
            coef_err <= coef_we && !coef_ok;
            if (coef_we && coef_ok) begin
                h_ram[coef_addr] <= coef_data;
            end
        end
    end

    // ---------------- multiply-accumulate ----------------
    fir_filter_mac_param_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .en    (mac_en),
        .x     (x_line[k]),
        .h     (h_ram[k]),
        .acc   (acc)
    );

    // ---------------- output stage ----------------
    assign result = round_sat(CALC_W'(acc), SHIFT, OUT_W);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            data_out  <= '0;
        end else if (load_out) begin
            out_valid <= 1'b1;
            data_out  <= result[OUT_W-1:0];
        end else if (out_done) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_filter_mac_param.sv
// Directed bench for fir_filter_mac_param (default parameters).
module tb_fir_filter_mac_param;
    import fir_filter_mac_param_pkg::*;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] data_in;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] data_out;
    logic               coef_we;
    logic [2:0]         coef_addr;
    logic signed [15:0] coef_data;
    logic               coef_err;
    fir_state_t         state_dbg;

    int checks = 0;
    int errors = 0;

    fir_filter_mac_param dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .coef_err  (coef_err),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    // cfg 0: default coefs, 1: h0=h1=0x4000, 2: all taps 0x7FFF
    typedef struct {
        int                 cfg;
        logic signed [15:0] din;
        logic signed [15:0] exp;
    } vec_t;

    localparam int NVEC = 26;
    vec_t vecs [NVEC];

    function automatic void set_vec(input int idx, input int cfg, input int din, input int exp);
        vecs[idx].cfg = cfg;
        vecs[idx].din = 16'(din);
        vecs[idx].exp = 16'(exp);
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic write_coef(input int addr, input int val);
        coef_we   = 1'b1;
        coef_addr = 3'(addr);
        coef_data = 16'(val);
        tick();
        coef_we   = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("reach_idle", in_ready, 1);
    endtask

    // Offers one sample, waits for acceptance and the result. lat counts edges
    // from the accepting edge to the one that raised out_valid.
    task automatic send_sample(input logic signed [15:0] d, output logic signed [15:0] res, output int lat);
        int n;
        in_valid = 1'b1;
        data_in  = d;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        res = data_out;
    endtask

    task automatic load_cfg(input int cfg);
        pulse_reset();
        if (cfg == 1) begin
            write_coef(0, 16'h4000);
            write_coef(1, 16'h4000);
        end else if (cfg == 2) begin
            for (int t = 0; t < 8; t++) begin
                write_coef(t, 16'h7FFF);
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic signed [15:0] res;
        int                 lat;
        int                 cur_cfg;
        int                 n;

        reset     = 1'b0;
        in_valid  = 1'b0;
        data_in   = '0;
        out_ready = 1'b1;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;

        set_vec(0, 0, 1, 1);
        set_vec(1, 0, 0, 0);
        set_vec(2, 0, 0, 0);
        set_vec(3, 0, -1, -1);
        set_vec(4, 0, 1000, 1000);
        set_vec(5, 1, 1000, 500);
        set_vec(6, 1, 1000, 1000);
        set_vec(7, 1, 1000, 1000);
        set_vec(8, 1, -1000, 0);
        set_vec(9, 1, -1000, -1000);
        for (int i = 0; i < 8; i++) begin
            set_vec(10 + i, 2, 32767, (i == 0) ? 32766 : 32767);
        end
        set_vec(18, 2, -32768, 32767);
        set_vec(19, 2, -32768, 32767);
        set_vec(20, 2, -32768, 32767);
        set_vec(21, 2, -32768, -4);
        for (int i = 22; i < 26; i++) begin
            set_vec(i, 2, -32768, -32768);
        end

        // reset state
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_coef_err", coef_err, 0);
        check("rst_in_ready", in_ready, 0);
        tick();
        reset = 1'b1;
        #1;
        check("idle_in_ready", in_ready, 1);

        // table-driven vectors
        cur_cfg = -1;
        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].cfg != cur_cfg) begin
                load_cfg(vecs[i].cfg);
                cur_cfg = vecs[i].cfg;
            end
            send_sample(vecs[i].din, res, lat);
            check($sformatf("vec%0d_data", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), lat, 9);
        end

        // backpressure: result held, in_ready low, waiting sample intact
        load_cfg(0);
        out_ready = 1'b0;
        send_sample(16'sd7, res, lat);
        check("bp_first", res, 7);
        in_valid = 1'b1;
        data_in  = 16'sd3;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("bp_hold_valid%0d", c), out_valid, 1);
            check($sformatf("bp_hold_data%0d", c), data_out, 7);
            check($sformatf("bp_hold_ready%0d", c), in_ready, 0);
        end
        out_ready = 1'b1;
        send_sample(16'sd3, res, lat);
        check("bp_next", res, 3);

        // coefficient write during MAC is dropped
        tick();
        wait_idle();
        in_valid = 1'b1;
        data_in  = 16'sd5;
        tick();
        in_valid = 1'b0;
        tick();
        coef_we   = 1'b1;
        coef_addr = 3'd0;
        coef_data = 16'sd0;
        tick();
        coef_we = 1'b0;
        check("mac_we_err_pulse", coef_err, 1);
        tick();
        check("mac_we_err_clear", coef_err, 0);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check("mac_we_result", data_out, 5);

        // write in OUT is dropped as well (state leaves OUT on this edge)
        coef_we   = 1'b1;
        coef_addr = 3'd0;
        coef_data = 16'sd0;
        tick();
        coef_we = 1'b0;
        check("out_we_err_pulse", coef_err, 1);
        wait_idle();
        send_sample(16'sd1, res, lat);
        check("coef_unchanged", res, 1);

        // legal write in IDLE takes effect, no error
        tick();
        wait_idle();
        write_coef(0, 16'h4000);
        check("idle_we_no_err", coef_err, 0);
        send_sample(16'sd2, res, lat);
        check("idle_we_applied", res, 1);

        // reset mid-MAC: outputs clear at once, defaults restored
        tick();
        wait_idle();
        in_valid = 1'b1;
        data_in  = 16'sd9;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_data_out", data_out, 0);
        tick();
        reset = 1'b1;
        send_sample(16'sd2, res, lat);
        check("midrst_default_h0", res, 2);
        send_sample(16'sd1, res, lat);
        check("midrst_impulse", res, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
